wall_query_arbiter: RTL

Time-multiplexes the single combinational wall-lookup port (pixel X/Y in, `wall_on` out) among several movers: Pac-Man and the ghosts. Each requester presents a candidate sprite top-left position. The block probes the sprite's bounding-box points against the wall map, one point per cycle, and returns a registered blocked/clear verdict. It sits between the movement FSMs and the wall map, ahead of the per-frame position update.

---
 rtl/wall_arb_pkg.sv | 24 ++
 rtl/wall_query_arbiter_rr_arbiter.sv | 28 ++
 rtl/wall_query_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wall_arb_pkg.sv
// Shared types and constants for the wall-lookup arbiter: FSM state encoding,
// probe counts, coordinate width and the saturating coordinate adder.
package wall_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int PROBES_CORNER = 4;
  localparam int PROBES_EDGE   = 8;
  localparam int COORD_W       = 10;
  localparam logic [COORD_W-1:0] COORD_MAX = 10'h3FF;

  // Probe points near the right/bottom screen edge clamp instead of wrapping to a small coordinate.
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] base,
                                                 input logic [COORD_W-1:0] off);
    logic [COORD_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return sum[COORD_W] ? COORD_MAX : sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/wall_query_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the most
// recently served index and wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest distance down to the nearest so the nearest requester overwrites.
  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = '0;
    cand          = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_i) + i) % NUM_REQ);
      if (req_i[cand]) begin
        grant_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/wall_query_arbiter.sv
// Shares one combinational wall-map port among sprite movers, probing bounding-box
// points one per cycle. Optional macro WALL_ARB_EDGE_PROBE_EN adds 4 edge midpoints.
module wall_query_arbiter
  import wall_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int SPRITE_S = 16
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][COORD_W-1:0] req_x,
  input  logic [NUM_REQ-1:0][COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ-1:0]              blocked,
  output logic                            busy,
  output logic [COORD_W-1:0]              probe_x,
  output logic [COORD_W-1:0]              probe_y,
  input  logic                            wall_on
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef WALL_ARB_EDGE_PROBE_EN
  localparam int NUM_PROBES = PROBES_EDGE;
  localparam int PIDX_W     = 3;
`else
  localparam int NUM_PROBES = PROBES_CORNER;
  localparam int PIDX_W     = 2;
`endif
  localparam logic [PIDX_W-1:0]  LAST_PIDX = PIDX_W'(NUM_PROBES - 1);
  localparam logic [COORD_W-1:0] OFF_FAR   = COORD_W'(SPRITE_S - 1);
  localparam logic [COORD_W-1:0] OFF_MID   = COORD_W'(SPRITE_S / 2);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [IDX_W-1:0]     win_q, win_d, last_q, last_d;
  logic [PIDX_W-1:0]    pidx_q, pidx_d;
  logic [NUM_REQ-1:0]   blocked_q, blocked_d;

  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic [COORD_W-1:0]   off_x, off_y, pt_x, pt_y;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i         (req),
    .last_i        (last_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Corner points first, then (optionally) the edge midpoints.
  always_comb begin
    off_x = '0;
    off_y = '0;
    case (pidx_q)
      PIDX_W'(1): off_x = OFF_FAR;
      PIDX_W'(2): off_y = OFF_FAR;
      PIDX_W'(3): begin off_x = OFF_FAR; off_y = OFF_FAR; end
`ifdef WALL_ARB_EDGE_PROBE_EN
      PIDX_W'(4): off_x = OFF_MID;
      PIDX_W'(5): off_y = OFF_MID;
      PIDX_W'(6): begin off_x = OFF_FAR; off_y = OFF_MID; end
      PIDX_W'(7): begin off_x = OFF_MID; off_y = OFF_FAR; end
`endif
      default: ;
    endcase
    pt_x = sat_add(x_q, off_x);
    pt_y = sat_add(y_q, off_y);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    win_d     = win_q;
    last_d    = last_q;
    pidx_d    = pidx_q;
    blocked_d = blocked_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          win_d   = grant_idx;
          x_d     = req_x[grant_idx];
          y_d     = req_y[grant_idx];
          pidx_d  = '0;
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (wall_on) begin
          blocked_d[win_q] = 1'b1;
          state_d          = ST_DONE;
        end else if (pidx_q == LAST_PIDX) begin
          blocked_d[win_q] = 1'b0;
          state_d          = ST_DONE;
        end else begin
          pidx_d = pidx_q + PIDX_W'(1);
        end
      end
      ST_DONE: begin
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      win_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      pidx_q    <= '0;
      blocked_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      win_q     <= win_d;
      last_q    <= last_d;
      pidx_q    <= pidx_d;
      blocked_q <= blocked_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack[gi] = (state_q == ST_DONE) && (win_q == IDX_W'(gi));
    end
  endgenerate

  assign blocked = blocked_q;
  assign busy    = (state_q != ST_IDLE);
  assign probe_x = (state_q == ST_PROBE) ? pt_x : '0;
  assign probe_y = (state_q == ST_PROBE) ? pt_y : '0;

endmodule
